// File: rtl/calc_acc_param.sv
// Parametrised register-mapped accumulator calculator with sticky flags and status readback.
// Optional multiply op is enabled by defining CALC_MUL_EN.
module calc_acc_param #(
  parameter int DW          = 8,
  parameter int AW          = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write_vld,
  input  logic          read_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_w,
  output logic [DW-1:0] data_r,
  output logic          calc_done,
  output logic          calc_ovf,
  output logic          calc_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_OP   = 2'd2;

  localparam logic [AW-1:0] ADDR_OPERAND = AW'(1);
  localparam logic [AW-1:0] ADDR_COMMAND = AW'(2);
  localparam logic [AW-1:0] ADDR_RESULT  = AW'(4);
  localparam logic [AW-1:0] ADDR_STATUS  = AW'(5);

  localparam logic [DW-1:0] CMD_CLEAR  = DW'(8'h00);
  localparam logic [DW-1:0] CMD_ADD    = DW'(8'h10);
  localparam logic [DW-1:0] CMD_SUB    = DW'(8'h20);
  localparam logic [DW-1:0] CMD_EQUALS = DW'(8'h30);
  localparam logic [DW-1:0] CMD_AND    = DW'(8'h40);
  localparam logic [DW-1:0] CMD_OR     = DW'(8'h50);
  localparam logic [DW-1:0] CMD_XOR    = DW'(8'h60);
`ifdef CALC_MUL_EN
  localparam logic [DW-1:0] CMD_MUL    = DW'(8'h70);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   in_vld;
  logic [1:0]             state;
  logic [DW-1:0]          acc;
  logic [DW-1:0]          pend_op;
  logic [DW-1:0]          alu_res;
  logic                   alu_ovf;
  logic                   cmd_is_op;
  logic                   wr_operand;
  logic                   wr_command;

  // The host strobe is asynchronous to us; synchronise, then keep only the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q[0] <= write_vld;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_vld     = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign wr_operand = in_vld && (addr == ADDR_OPERAND);
  assign wr_command = in_vld && (addr == ADDR_COMMAND);

`ifdef CALC_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, acc} * {{DW{1'b0}}, data_w};
`endif

  always_comb begin
    cmd_is_op = (data_w == CMD_ADD) || (data_w == CMD_SUB) || (data_w == CMD_AND) ||
                (data_w == CMD_OR)  || (data_w == CMD_XOR);
`ifdef CALC_MUL_EN
    if (data_w == CMD_MUL) cmd_is_op = 1'b1;
`endif
  end

  always_comb begin
    alu_res = acc;
    alu_ovf = 1'b0;
    case (pend_op)
      CMD_ADD: {alu_ovf, alu_res} = {1'b0, acc} + {1'b0, data_w};
      CMD_SUB: begin
        alu_res = acc - data_w;
        alu_ovf = (acc < data_w);
      end
      CMD_AND: alu_res = acc & data_w;
      CMD_OR:  alu_res = acc | data_w;
      CMD_XOR: alu_res = acc ^ data_w;
`ifdef CALC_MUL_EN
      CMD_MUL: begin
        alu_res = prod[DW-1:0];
        alu_ovf = |prod[2*DW-1:DW];
      end
`endif
      default: ;
    endcase
  end

  // CLEAR wins in any state; everything else follows the IDLE/DATA/OP protocol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      pend_op   <= CMD_ADD;
      calc_done <= 1'b0;
      calc_ovf  <= 1'b0;
      calc_err  <= 1'b0;
    end else if (wr_command && (data_w == CMD_CLEAR)) begin
      state     <= ST_IDLE;
      acc       <= '0;
      calc_done <= 1'b0;
      calc_ovf  <= 1'b0;
      calc_err  <= 1'b0;
    end else if (wr_operand) begin
      case (state)
        ST_IDLE: begin
          acc       <= data_w;
          calc_done <= 1'b0;
          calc_ovf  <= 1'b0;
          calc_err  <= 1'b0;
          state     <= ST_DATA;
        end
        ST_OP: begin
          acc <= alu_res;
          if (alu_ovf) calc_ovf <= 1'b1;
          state <= ST_DATA;
        end
        default: calc_err <= 1'b1;
      endcase
    end else if (wr_command) begin
      case (state)
        ST_DATA: begin
          if (cmd_is_op) begin
            pend_op <= data_w;
            state   <= ST_OP;
          end else if (data_w == CMD_EQUALS) begin
            calc_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            calc_err <= 1'b1;
          end
        end
        ST_OP: begin
          if (cmd_is_op) pend_op <= data_w;
          else           calc_err <= 1'b1;
        end
        default: calc_err <= 1'b1;
      endcase
    end
  end

  // Reads see the registers before any update landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (read_en) begin
      case (addr)
        ADDR_RESULT: data_r <= acc;
        ADDR_STATUS: data_r <= {{(DW-5){1'b0}}, state, calc_err, calc_ovf, calc_done};
        default:     data_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_acc_param.sv
// Self-checking bench for calc_acc_param: directed sequences with literal results plus
// randomized host traffic compared every cycle against a transaction-level model.
module tb_calc_acc_param;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_vld;
  logic          read_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_w;
  logic [DW-1:0] data_r;
  logic          calc_done;
  logic          calc_ovf;
  logic          calc_err;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state: 0 = IDLE, 1 = DATA, 2 = OP
  int            m_state;
  logic [DW-1:0] m_acc;
  logic [DW-1:0] m_pend;
  logic          m_done, m_ovf, m_err;
  logic [DW-1:0] exp_data_r;

  calc_acc_param #(.DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .write_vld(write_vld), .read_en(read_en),
    .addr(addr), .data_w(data_w), .data_r(data_r),
    .calc_done(calc_done), .calc_ovf(calc_ovf), .calc_err(calc_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isOp(input logic [DW-1:0] c);
    bit r;
    r = (c == 8'h10) || (c == 8'h20) || (c == 8'h40) || (c == 8'h50) || (c == 8'h60);
`ifdef CALC_MUL_EN
    if (c == 8'h70) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] modelStatus();
    return DW'((m_state << 3) | (int'(m_err) << 2) | (int'(m_ovf) << 1) | int'(m_done));
  endfunction

  task automatic modelReset();
    m_state = 0; m_acc = '0; m_pend = 8'h10;
    m_done = 0; m_ovf = 0; m_err = 0;
    exp_data_r = '0;
  endtask

  task automatic modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    longint unsigned x, y, r;
    x = m_acc; y = d;
    if (a == 1) begin
      if (m_state == 0) begin
        m_acc = d; m_done = 0; m_ovf = 0; m_err = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_err = 1;
      end else begin
        case (m_pend)
          8'h10: begin r = x + y; if (r >= (64'd1 << DW)) m_ovf = 1; end
          8'h20: begin if (x < y) m_ovf = 1; r = x + (64'd1 << DW) - y; end
          8'h40: r = x & y;
          8'h50: r = x | y;
          8'h60: r = x ^ y;
          8'h70: begin r = x * y; if ((r >> DW) != 0) m_ovf = 1; end
          default: r = x;
        endcase
        m_acc = DW'(r % (64'd1 << DW));
        m_state = 1;
      end
    end else if (a == 2) begin
      if (d == 8'h00) begin
        m_acc = '0; m_done = 0; m_ovf = 0; m_err = 0; m_state = 0;
      end else if (m_state == 0) begin
        m_err = 1;
      end else if (m_state == 1) begin
        if (isOp(d)) begin m_pend = d; m_state = 2; end
        else if (d == 8'h30) begin m_done = 1; m_state = 0; end
        else m_err = 1;
      end else begin
        if (isOp(d)) m_pend = d;
        else m_err = 1;
      end
    end
  endtask

  // Raise write_vld for `hold` cycles; the write takes effect on edge SS+1.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    addr = a; data_w = d; write_vld = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      if (k == SS + 1) modelWrite(a, d);
    end
    @(negedge clk);
    write_vld = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic writeReg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(a, d, SS + 2);
  endtask

  task automatic readReg(input logic [AW-1:0] a, output logic [DW-1:0] v);
    logic [DW-1:0] e;
    @(negedge clk);
    read_en = 1'b1; addr = a;
    e = (a == 4) ? m_acc : (a == 5) ? modelStatus() : '0;
    @(posedge clk);
    exp_data_r = e;
    @(negedge clk);
    v = data_r;
    read_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("data_r",    data_r,    exp_data_r);
      checkOutput("calc_done", calc_done, m_done);
      checkOutput("calc_ovf",  calc_ovf,  m_ovf);
      checkOutput("calc_err",  calc_err,  m_err);
    end
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] codes [10];
    int r;
    rst_n = 1'b0; write_vld = 1'b0; read_en = 1'b0; addr = '0; data_w = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_data_r", data_r, 0);
    checkOutput("reset_flags", {calc_done, calc_ovf, calc_err}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    writeReg(1, 8'h05); writeReg(2, 8'h10); writeReg(1, 8'h03); writeReg(2, 8'h30);
    checkOutput("add_done", calc_done, 1);
    readReg(4, v); checkOutput("add_result", v, 8'h08);
    readReg(5, v); checkOutput("add_status", v, 8'h01);

    writeReg(1, 8'hF0); writeReg(2, 8'h10); writeReg(1, 8'h20); writeReg(2, 8'h30);
    readReg(4, v); checkOutput("carry_result", v, 8'h10);
    checkOutput("carry_ovf", calc_ovf, 1);
    writeReg(1, 8'h02);
    checkOutput("first_operand_clears", {calc_ovf, calc_done}, 0);
    writeReg(2, 8'h30);

    writeReg(1, 8'h03); writeReg(2, 8'h20); writeReg(1, 8'h05); writeReg(2, 8'h30);
    readReg(4, v); checkOutput("borrow_result", v, 8'hFE);
    checkOutput("borrow_ovf", calc_ovf, 1);
    writeReg(1, 8'hCC); writeReg(2, 8'h40); writeReg(1, 8'h0F);
    writeReg(2, 8'h60); writeReg(1, 8'hFF); writeReg(2, 8'h30);
    readReg(4, v); checkOutput("logic_chain", v, 8'hF3);

    writeReg(1, 8'h01); writeReg(1, 8'h02);
    checkOutput("double_operand_err", calc_err, 1);
    readReg(4, v); checkOutput("double_operand_acc", v, 8'h01);
    writeReg(2, 8'h99);
    checkOutput("invalid_cmd_err", calc_err, 1);
    writeReg(2, 8'h00);
    readReg(5, v); checkOutput("clear_status", v, 8'h00);
    readReg(4, v); checkOutput("clear_acc", v, 8'h00);

    // A 20-cycle write pulse must count as a single operand write.
    writeReg(1, 8'h01); writeReg(2, 8'h10);
    applyStimulus(1, 8'h01, 20);
    readReg(4, v); checkOutput("held_strobe_acc", v, 8'h02);
    readReg(5, v); checkOutput("held_strobe_status", v, 8'h08);
    writeReg(2, 8'h10);
    @(negedge clk);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {data_r, calc_done, calc_ovf, calc_err}, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    readReg(5, v); checkOutput("post_reset_status", v, 8'h00);

`ifdef CALC_MUL_EN
    writeReg(1, 8'h10); writeReg(2, 8'h70); writeReg(1, 8'h20); writeReg(2, 8'h30);
    readReg(4, v); checkOutput("mul_result", v, 8'h00);
    checkOutput("mul_ovf", calc_ovf, 1);
`else
    writeReg(1, 8'h10); writeReg(2, 8'h70);
    readReg(5, v); checkOutput("mul_disabled_status", v, 8'h0C);
`endif
    writeReg(2, 8'h00);

    codes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h30, 8'h00, 8'h99};
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 38) begin
        writeReg(1, DW'($urandom));
      end else if (r < 75) begin
        v = codes[$urandom_range(0, 9)];
        if (v == 8'h99) v = DW'($urandom);
        writeReg(2, v);
      end else if (r < 82) begin
        writeReg(AW'($urandom_range(3, 127)), DW'($urandom));
      end else begin
        r = $urandom_range(0, 2);
        readReg((r == 0) ? AW'(4) : (r == 1) ? AW'(5) : AW'($urandom), v);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
